// File: rtl/shared_delay_scheduler.sv
// Shares one down-counter among N_REQ requesters that each want a one-shot delay.
// Define SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module shared_delay_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DELAY_W = 27
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DELAY_W-1:0] delay,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         state;
    logic [DELAY_W-1:0] counter;
    logic [IDX_W-1:0]   owner;

    logic [DELAY_W-1:0] dly [N_REQ];
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_onehot;
    logic [DELAY_W-1:0] win_dly;
    logic [DELAY_W-1:0] load_val;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_unpack
            assign dly[g] = delay[g*DELAY_W +: DELAY_W];
        end
    endgenerate

`ifdef SCHED_FIXED_PRIO_EN
    // Scan downward so the lowest set index is the last (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`else
    localparam logic [IDX_W:0]   N_L  = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Search starts at ptr and wraps; the first hit wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= N_L) begin
                sum = sum - N_L;
            end
            cand = sum[IDX_W-1:0];
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Pointer only advances on a completed delay; aborts leave it alone.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (state == DONE) begin
            ptr <= (owner == LAST) ? '0 : owner + 1'b1;
        end
    end
`endif

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    // A zero delay behaves as one cycle, so both 0 and 1 load the counter with 0.
    assign win_dly  = dly[win_idx];
    assign load_val = (win_dly == '0) ? '0 : win_dly - 1'b1;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state   <= IDLE;
            counter <= '0;
            owner   <= '0;
            grant   <= '0;
            done    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner   <= win_idx;
                        counter <= load_val;
                        grant   <= win_onehot;
                        state   <= COUNT;
                    end
                end
                COUNT: begin
                    if (!req[owner]) begin
                        grant <= '0;
                        state <= IDLE;
                    end else if (counter == '0) begin
                        grant <= '0;
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    done  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_delay_scheduler.sv
// Bench for shared_delay_scheduler: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requester traffic.
module tb_shared_delay_scheduler;

    localparam int N  = 4;
    localparam int DW = 27;

    logic            clk_in  = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req     = '0;
    logic [N*DW-1:0] delay   = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;

    shared_delay_scheduler #(.N_REQ(N), .DELAY_W(DW)) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .req    (req),
        .delay  (delay),
        .grant  (grant),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: edge count, current owner and the edge at which its grant ends.
    int           cyc    = 0;
    bit           act    = 1'b0;
    int           own    = 0;
    int           endc   = 0;
    int           nxt    = 0;
    int           ptr    = 0;
    bit           mv     = 1'b0;
    logic [N-1:0] eg     = '0;
    logic [N-1:0] ed     = '0;
    logic         eb     = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] r;
        int c, d;
        r = req;
        cyc++;
        ed = '0;
        if (!reset_n) begin
            act = 1'b0;
            ptr = 0;
            nxt = cyc + 1;
        end else if (act) begin
            if (!r[own]) begin
                act = 1'b0;
                nxt = cyc + 1;
            end else if (cyc == endc) begin
                act     = 1'b0;
                ed[own] = 1'b1;
                ptr     = (own + 1) % N;
                nxt     = cyc + 2;
            end
        end else if (cyc >= nxt && r != '0) begin
            for (int i = N - 1; i >= 0; i--) begin
`ifdef SCHED_FIXED_PRIO_EN
                c = i;
`else
                c = (ptr + i) % N;
`endif
                if (r[c]) own = c;
            end
            d    = int'(delay[own*DW +: DW]);
            act  = 1'b1;
            endc = cyc + ((d == 0) ? 1 : d);
        end
        eg = '0;
        if (act) eg[own] = 1'b1;
        eb = act || (ed != '0);
        mv = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (mv) begin
                chk("grant", 32'(grant), 32'(eg));
                chk("done", 32'(done), 32'(ed));
                chk("busy", 32'(busy), 32'(eb));
                chk("grant onehot0", 32'($onehot0(grant)), 32'd1);
                chk("done/grant overlap", 32'(done & grant), 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic set_delay(input int ch, input int d);
        delay[ch*DW +: DW] = DW'(d);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic run_one(input int ch, input int d, output int width,
                           output logic [N-1:0] dval, output logic bval);
        int n = 0;
        set_delay(ch, d);
        req[ch] = 1'b1;
        while (grant[ch] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        width = 0;
        while (grant[ch] === 1'b1 && width < 300) begin
            tick();
            width++;
        end
        dval    = done;
        req[ch] = 1'b0;
        tick();
        bval = busy;
    endtask

    initial begin
        int           w;
        logic [N-1:0] dv;
        logic         bv;
        int           n;
        int           order[5];
        int           cnt;
        logic [N-1:0] prev;
        int           exp_ch;

        // Reset held with every request up.
        reset_n = 1'b0;
        req     = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset grant", 32'(grant), 32'd0);
            chk("reset done", 32'(done), 32'd0);
            chk("reset busy", 32'(busy), 32'd0);
        end
        req     = '0;
        reset_n = 1'b1;
        tick();

        run_one(2, 5, w, dv, bv);
        chk("single width", 32'(w), 32'd5);
        chk("single done", 32'(dv), 32'b0100);
        chk("single busy after", 32'(bv), 32'd0);

        run_one(1, 0, w, dv, bv);
        chk("zero width", 32'(w), 32'd1);
        chk("zero done", 32'(dv), 32'b0010);

        // Abort channel 3 after four grant cycles.
        set_delay(3, 10);
        req[3] = 1'b1;
        n = 0;
        while (grant[3] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("abort granted", 32'(grant), 32'b1000);
        for (int k = 0; k < 3; k++) tick();
        req[3] = 1'b0;
        tick();
        chk("abort grant", 32'(grant), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        tick();
        chk("abort done later", 32'(done), 32'd0);
        set_delay(1, 4);
        set_delay(3, 4);
        req = 4'b1010;
        n = 0;
        while (grant === '0 && n < 10) begin
            tick();
            n++;
        end
`ifdef SCHED_FIXED_PRIO_EN
        chk("abort ptr kept", 32'(grant), 32'b0010);
`else
        chk("abort ptr kept", 32'(grant), 32'b1000);
`endif
        req = '0;
        tick();
        tick();

        // Reset in the middle of a long count.
        set_delay(0, 100);
        req = 4'b0001;
        n = 0;
        while (grant[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 10; k++) tick();
        reset_n = 1'b0;
        tick();
        chk("midreset grant", 32'(grant), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("midreset regrant", 32'(grant), 32'b0001);
        req = '0;
        tick();
        tick();

        // Fairness: fresh pointer, everyone asks for 3 cycles and re-asks after done.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_delay(i, 3);
        req  = '1;
        cnt  = 0;
        prev = '0;
        for (int k = 0; k < 200 && cnt < 5; k++) begin
            tick();
            if (grant != '0 && prev == '0) begin
                order[cnt] = idx_of(grant);
                cnt++;
            end
            prev = grant;
            req  = ~done;
        end
        chk("rr grant count", 32'(cnt), 32'd5);
        for (int j = 0; j < 5; j++) begin
`ifdef SCHED_FIXED_PRIO_EN
            exp_ch = 0;
`else
            exp_ch = j % N;
`endif
            chk("rr order", 32'(order[j]), 32'(exp_ch));
        end
        req = '0;
        tick();
        tick();

        // Random traffic; delays keep changing to show they are only sampled at grant.
        for (int k = 0; k < 3000; k++) begin
            tick();
            reset_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && done[i]) req[i] = 1'b0;
                else if (req[i] && grant[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 7) == 0) set_delay(i, int'($urandom_range(0, 40)));
                    else set_delay(i, int'($urandom_range(0, 6)));
                end
            end
        end
        reset_n = 1'b1;
        req     = '0;
        for (int k = 0; k < 5; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
